soc_system_pio_in_edge: RTL and testbench
=========================================

// Module: soc_system_pio_in_edge
// PURPOSE
//  Parametrised Avalon-MM input PIO. Successor to the fixed 8-bit input-only PIO.
//  Adds a configurable port width, an N-stage input synchroniser, per-bit edge
//  capture with write-1-to-clear, and a maskable level interrupt to the HPS.
//  Sits on the lightweight HPS-to-FPGA bridge; samples switches/buttons/status lines.
// PARAMETERS
//  DATA_WIDTH   8  in_port width, legal 1..32; readdata bits above DATA_WIDTH read 0
//  SYNC_STAGES  2  synchroniser flops on in_port, legal 2..4
//  EDGE_TYPE    0  0=rising, 1=falling, 2=any edge sets edge_capture
//  IRQ_EN       1  0: irq tied 0; irqmask reg reads 0; writes to it ignored
// PORTS
//  clk        in   1           system clock
//  reset_n    in   1           async active-low reset
//  address    in   2           word offset of register
//  chipselect in   1           slave select
//  write_n    in   1           active-low write strobe (qualified by chipselect)
//  writedata  in   32          write data
//  in_port    in   DATA_WIDTH  asynchronous external inputs
//  readdata   out  32          registered read data
//  irq        out  1           level interrupt, high while any unmasked capture bit is set
// BEHAVIOUR
//  Clock/reset: one clock clk. reset_n is asynchronous assert, active-low.
//  Reset values: readdata=0, irq=0, sync chain=0, prev=0, irqmask=0, edge_capture=0,
//  warm-up counter=0.
//  Register map (word offsets):
//   0 DATA     RO  synchronised in_port; writes ignored
//   1 reserved RO  reads 0; writes ignored
//   2 IRQMASK  RW  DATA_WIDTH bits; 1 = bit enabled onto irq
//   3 EDGECAP  RW1C  sticky edge flags; writing 1 to a bit clears it
//  Read: readdata is updated every cycle from the mux on address; read latency is 1 cycle.
//  Unused upper bits are zero-filled.
//  Write: takes effect on a clk edge where chipselect=1 and write_n=0; no wait states.
//  Sync: sync_out = last flop of the SYNC_STAGES chain.
//   in_port change before edge k appears in sync_out after edge k+SYNC_STAGES-1.
//   It appears in readdata (addr 0) after edge k+SYNC_STAGES.
//  Edge detect: prev <= sync_out every cycle.
//   rise = sync_out & ~prev; fall = ~sync_out & prev.
//   EDGE_TYPE selects rise, fall or rise|fall.
//  Warm-up: a counter counts from 0 to SYNC_STAGES+1 after reset, then saturates.
//   While it is below SYNC_STAGES+1, no edge_capture bit may be set.
//   This stops inputs that are already high at reset from producing spurious edges.
//  edge_capture[i] next = (edge_capture[i] & ~clr[i]) | det[i].
//   clr[i] = write to 3 with writedata[i]=1.
//   A simultaneous detect and clear on the same bit leaves the bit SET (edge wins).
//  irq = |(edge_capture & irqmask), from registers. Asserts on the cycle after
//   edge_capture sets, or immediately after an IRQMASK write that unmasks a set bit.
//  Boundaries:
//   - Repeated edges on a set bit: no change (no counting).
//   - Glitch shorter than 1 clk: may be missed; no requirement.
//   - DATA_WIDTH=32: no zero fill.
//   - Reset mid-operation: all state clears; the warm-up counter restarts.
// TESTING
//  1 Reset with in_port=8'hFF held; release; wait 10 clk; read 3 -> 0x00, irq=0.
//    Read 0 -> 0x000000FF.
//  2 in_port 0x00->0x01 at edge k (SYNC_STAGES=2): readdata(addr0)=0x01 after edge k+2.
//    Read 3 -> 0x01. irq stays 0 (mask=0).
//  3 Write IRQMASK=0x01 with EDGECAP bit0 set: irq=1 the next cycle.
//    Write 3 with 0x01: EDGECAP=0 and irq=0 the next cycle.
//  4 Clear bit0 in the same cycle that a new rising edge on bit0 is detected:
//    EDGECAP bit0 stays 1 and irq stays 1.
//  5 EDGE_TYPE=1: drive 0x03->0x01 -> EDGECAP=0x02. EDGE_TYPE=2: pulse bit2 -> EDGECAP=0x04.
//  6 DATA_WIDTH=12, in_port=12'hABC: read 0 -> 0x00000ABC. Write 0 / 1: no effect.
//    Assert reset_n mid-test: all regs read 0 and irq=0.

Source files
------------

// File: rtl/soc_system_pio_in_edge.sv
// Avalon-MM input PIO: synchronised DATA, maskable IRQ, sticky W1C edge capture.
// Read latency 1 cycle, writes take effect in 0 wait states; the slave never stalls.
// Backpressure: none, because every access completes on the cycle it is presented.
module soc_system_pio_in_edge #(
    parameter int DATA_WIDTH  = 8,   // 1..32
    parameter int SYNC_STAGES = 2,   // 2..4
    parameter int EDGE_TYPE   = 0,   // 0 rising, 1 falling, 2 any
    parameter int IRQ_EN      = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    localparam int WARM_MAX = SYNC_STAGES + 1;
    localparam int WARM_W   = $clog2(WARM_MAX + 1);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    typedef logic [DATA_WIDTH-1:0] data_t;

    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q, sync_d;
    data_t              prev_q, prev_d;
    data_t              irqmask_q, irqmask_d;
    data_t              edge_cap_q, edge_cap_d;
    logic [WARM_W-1:0]  warm_q, warm_d;
    logic [31:0]        readdata_q, readdata_d;

    data_t sync_out;
    data_t rise, fall, det;
    data_t clr;
    logic  wr_en;
    logic  warm_done;

    // Only the low DATA_WIDTH bits of writedata reach a register.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    function automatic logic [31:0] zext(input data_t v);
        logic [31:0] r;
        r                 = '0;
        r[DATA_WIDTH-1:0] = v;
        return r;
    endfunction

    assign sync_out  = sync_q[SYNC_STAGES-1];
    assign wr_en     = chipselect & ~write_n;
    assign warm_done = (warm_q == WARM_W'(WARM_MAX));

    always_comb begin
        sync_d[0] = in_port;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign prev_d = sync_out;
    assign rise   = sync_out & ~prev_q;
    assign fall   = ~sync_out & prev_q;

    // Edges are ignored until the chain and prev hold real samples, so
    // inputs already high at reset release do not look like rising edges.
    always_comb begin
        det = '0;
        if (warm_done) begin
            case (EDGE_TYPE)
                0:       det = rise;
                1:       det = fall;
                default: det = rise | fall;
            endcase
        end
    end

    always_comb begin
        warm_d = warm_q;
        if (!warm_done) begin
            warm_d = warm_q + 1'b1;
        end
    end

    always_comb begin
        clr = '0;
        if (wr_en && address == ADDR_EDGECAP) begin
            clr = writedata[DATA_WIDTH-1:0];
        end
    end

    // A detect in the same cycle as a clear wins, so no edge is ever lost.
    assign edge_cap_d = (edge_cap_q & ~clr) | det;

    always_comb begin
        irqmask_d = irqmask_q;
        if (IRQ_EN == 0) begin
            irqmask_d = '0;
        end else if (wr_en && address == ADDR_IRQMASK) begin
            irqmask_d = writedata[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:    readdata_d = zext(sync_out);
            ADDR_IRQMASK: readdata_d = zext(irqmask_q);
            ADDR_EDGECAP: readdata_d = zext(edge_cap_q);
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            prev_q     <= '0;
            irqmask_q  <= '0;
            edge_cap_q <= '0;
            warm_q     <= '0;
            readdata_q <= '0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            irqmask_q  <= irqmask_d;
            edge_cap_q <= edge_cap_d;
            warm_q     <= warm_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_cap_q & irqmask_q);

endmodule

// File: tb/tb_soc_system_pio_in_edge.sv
// Directed bench for soc_system_pio_in_edge: four instances (rising, falling,
// any-edge, 12-bit) with expected values queued at stimulus and popped at compare.
module tb_soc_system_pio_in_edge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic [3:0]  cs;
    logic        write_n;
    logic [31:0] writedata;

    logic [7:0]  in8, in_fall, in_any;
    logic [11:0] in12;
    logic [31:0] rd0, rd1, rd2, rd3;
    logic        irq0, irq1, irq2, irq3;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    soc_system_pio_in_edge #(.DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_EN(1)) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]), .write_n(write_n),
        .writedata(writedata), .in_port(in8), .readdata(rd0), .irq(irq0));

    soc_system_pio_in_edge #(.DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1), .IRQ_EN(1)) dut_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[1]), .write_n(write_n),
        .writedata(writedata), .in_port(in_fall), .readdata(rd1), .irq(irq1));

    soc_system_pio_in_edge #(.DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_EN(1)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[2]), .write_n(write_n),
        .writedata(writedata), .in_port(in_any), .readdata(rd2), .irq(irq2));

    soc_system_pio_in_edge #(.DATA_WIDTH(12), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_EN(1)) dut_w12 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[3]), .write_n(write_n),
        .writedata(writedata), .in_port(in12), .readdata(rd3), .irq(irq3));

    function automatic logic [31:0] rdat(input int which);
        case (which)
            0:       return rd0;
            1:       return rd1;
            2:       return rd2;
            default: return rd3;
        endcase
    endfunction

    function automatic logic irq_of(input int which);
        case (which)
            0:       return irq0;
            1:       return irq1;
            2:       return irq2;
            default: return irq3;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic expect_val(input string tag, input logic [31:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic compare(input logic [31:0] got);
        logic [31:0] e;
        string       t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=0x%08h expected=none", got);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (got === e) else begin
                errors++;
                $error("FAIL %s observed=0x%08h expected=0x%08h", t, got, e);
            end
        end
    endtask

    task automatic rd(input int which, input logic [1:0] a, input logic [31:0] e, input string tag);
        address   = a;
        write_n   = 1'b1;
        cs        = '0;
        cs[which] = 1'b1;
        expect_val(tag, e);
        step();
        cs = '0;
        compare(rdat(which));
    endtask

    task automatic wr(input int which, input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        cs        = '0;
        cs[which] = 1'b1;
        step();
        cs        = '0;
        write_n   = 1'b1;
    endtask

    task automatic chk_irq(input int which, input logic e, input string tag);
        expect_val(tag, {31'b0, e});
        compare({31'b0, irq_of(which)});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        address   = 2'd0;
        cs        = '0;
        write_n   = 1'b1;
        writedata = '0;
        in8       = 8'hFF;
        in_fall   = 8'h00;
        in_any    = 8'h00;
        in12      = 12'h000;

        // Reset with inputs held high: no spurious captures after warm-up.
        idle(3);
        expect_val("reset_readdata", 32'h0);
        compare(rd0);
        chk_irq(0, 1'b0, "reset_irq");
        reset_n = 1'b1;
        idle(10);
        rd(0, 2'd3, 32'h0000_0000, "t1_edgecap_after_warmup");
        chk_irq(0, 1'b0, "t1_irq");
        rd(0, 2'd0, 32'h0000_00FF, "t1_data");
        rd(0, 2'd2, 32'h0000_0000, "t1_irqmask_reset");

        // Synchroniser latency and rising-edge capture.
        in8 = 8'h00;
        idle(6);
        rd(0, 2'd3, 32'h0000_0000, "t2_fall_not_captured");
        address = 2'd0;
        step();
        in8 = 8'h01;
        step();
        expect_val("t2_data_edge_k1", 32'h0000_0000);
        step();
        compare(rd0);
        expect_val("t2_data_edge_k2", 32'h0000_0001);
        step();
        compare(rd0);
        idle(2);
        rd(0, 2'd3, 32'h0000_0001, "t2_edgecap");
        chk_irq(0, 1'b0, "t2_irq_masked");

        // Unmask then clear.
        wr(0, 2'd2, 32'h0000_0001);
        chk_irq(0, 1'b1, "t3_irq_after_unmask");
        rd(0, 2'd2, 32'h0000_0001, "t3_irqmask");
        wr(0, 2'd3, 32'h0000_0001);
        chk_irq(0, 1'b0, "t3_irq_after_clear");
        rd(0, 2'd3, 32'h0000_0000, "t3_edgecap_cleared");

        // Clear coinciding with a fresh detect: edge wins.
        in8 = 8'h00;
        idle(4);
        in8 = 8'h01;
        idle(4);
        chk_irq(0, 1'b1, "t4_irq_preset");
        in8 = 8'h00;
        idle(4);
        in8 = 8'h01;
        step();
        step();
        wr(0, 2'd3, 32'h0000_0001);
        chk_irq(0, 1'b1, "t4_irq_edge_wins");
        rd(0, 2'd3, 32'h0000_0001, "t4_edgecap_edge_wins");
        wr(0, 2'd3, 32'h0000_0001);
        chk_irq(0, 1'b0, "t4_irq_plain_clear");
        rd(0, 2'd3, 32'h0000_0000, "t4_edgecap_plain_clear");

        // Falling-edge and any-edge instances.
        in_fall = 8'h03;
        idle(5);
        rd(1, 2'd3, 32'h0000_0000, "t5_fall_ignores_rise");
        in_fall = 8'h01;
        idle(5);
        rd(1, 2'd3, 32'h0000_0002, "t5_fall_capture");
        in_any = 8'h04;
        idle(5);
        rd(2, 2'd3, 32'h0000_0004, "t5_any_rise");
        wr(2, 2'd3, 32'h0000_0004);
        rd(2, 2'd3, 32'h0000_0000, "t5_any_cleared");
        in_any = 8'h00;
        idle(5);
        rd(2, 2'd3, 32'h0000_0004, "t5_any_fall");

        // 12-bit instance: zero fill, ignored writes, mid-run reset.
        in12 = 12'hABC;
        idle(5);
        rd(3, 2'd0, 32'h0000_0ABC, "t6_data_w12");
        rd(3, 2'd3, 32'h0000_0ABC, "t6_edgecap_w12");
        wr(3, 2'd0, 32'hFFFF_FFFF);
        wr(3, 2'd1, 32'hFFFF_FFFF);
        rd(3, 2'd0, 32'h0000_0ABC, "t6_data_after_write");
        rd(3, 2'd1, 32'h0000_0000, "t6_reserved");
        wr(3, 2'd2, 32'hFFFF_FFFF);
        rd(3, 2'd2, 32'h0000_0FFF, "t6_irqmask_zero_fill");
        chk_irq(3, 1'b1, "t6_irq_w12");

        reset_n = 1'b0;
        #2;
        expect_val("t6_reset_readdata_async", 32'h0);
        compare(rd3);
        chk_irq(3, 1'b0, "t6_reset_irq_async");
        idle(2);
        reset_n = 1'b1;
        idle(10);
        rd(3, 2'd3, 32'h0000_0000, "t6_edgecap_after_reset");
        rd(3, 2'd2, 32'h0000_0000, "t6_irqmask_after_reset");
        chk_irq(3, 1'b0, "t6_irq_after_reset");
        rd(3, 2'd0, 32'h0000_0ABC, "t6_data_after_reset");
        rd(0, 2'd3, 32'h0000_0000, "t6_rise_edgecap_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
